spi_slave: RTL and testbench

SPI responder (slave) for one 8-bit-word SPI link, clocked from the 10 MHz system clock. It oversamples the external SCLK, CS_n and MOSI pins through synchronizers and shifts a received byte in while shifting a preloaded byte out on MISO. The block is the peer of the team's SPI master and defaults to that master's mode 3 (CPOL=1, CPHA=1). It sits between the board pins and a register/FSM client that exchanges bytes through a load/valid handshake.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
// spi_pkg: definitions shared by the SPI responder and the SPI master.
//   state_t        - frame FSM states (IDLE, LOAD, SHIFT)
//   MODE0..MODE3   - SPI mode encodings as {CPOL, CPHA}
//   DEFAULT_DATA_W - default word width in bits
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// spi_sync_edge: two-flop synchronizer for an asynchronous pin, followed by a
// third flop used to detect transitions of the synchronized level.
//   clk      - system clock
//   rst      - synchronous active-high reset
//   async_in - asynchronous pin
//   sync_out - synchronized level
//   rise     - one-cycle pulse on a synchronized 0->1 transition
//   fall     - one-cycle pulse on a synchronized 1->0 transition
// RESET_VAL is the pin's idle level, so leaving reset on an idle pin produces
// no spurious edge.
module spi_sync_edge #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= {3{RESET_VAL}};
        end else begin
            sh <= {sh[1:0], async_in};
        end
    end

    assign sync_out = sh[1];
    assign rise     = sh[1] & ~sh[2];
    assign fall     = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: SPI responder for one DATA_W-bit word link, oversampling the
// SPI pins with the system clock. Receives MSB first on MOSI while sending a
// preloaded word MSB first on MISO.
//   clk_i, reset_i        - system clock, synchronous active-high reset
//   sclk_i, cs_n_i, mosi_i - asynchronous SPI pins
//   miso_o, miso_oe_o     - serial data out and its output enable
//   tx_data_i, tx_load_i  - client write into the TX buffer (when tx_ready_o)
//   tx_ready_o            - TX buffer empty
//   rx_data_o, rx_valid_o - last complete word, one-cycle update pulse
//   rx_abort_o            - one-cycle pulse: CS_n released mid-word
//   busy_o                - frame in progress
module spi_slave
    import spi_pkg::*;
#(
    parameter bit CPOL   = 1'b1,
    parameter bit CPHA   = 1'b1,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              rx_abort_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // ---- stage 0: pin synchronizers and edge detection ----
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic mosi_meta, mosi_s;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
        .clk      (clk_i),
        .rst      (reset_i),
        .async_in (sclk_i),
        .sync_out (sclk_s),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk_i),
        .rst      (reset_i),
        .async_in (cs_n_i),
        .sync_out (cs_n_s),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Leading edge moves SCLK away from its idle level, trailing edge back.
    logic sclk_chg, leading, trailing, sample_edge, shift_edge;
    assign sclk_chg    = sclk_rise | sclk_fall;
    assign leading     = sclk_chg & (sclk_s != CPOL);
    assign trailing    = sclk_chg & (sclk_s == CPOL);
    assign sample_edge = CPHA ? trailing : leading;
    assign shift_edge  = CPHA ? leading  : trailing;

    // ---- stage 1: registered edge events, MOSI aligned with them ----
    logic sample_p1, shift_p1, cs_rise_p1, cs_fall_p1, mosi_p1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mosi_meta  <= 1'b0;
            mosi_s     <= 1'b0;
            mosi_p1    <= 1'b0;
            sample_p1  <= 1'b0;
            shift_p1   <= 1'b0;
            cs_rise_p1 <= 1'b0;
            cs_fall_p1 <= 1'b0;
        end else begin
            mosi_meta  <= mosi_i;
            mosi_s     <= mosi_meta;
            mosi_p1    <= mosi_s;
            sample_p1  <= sample_edge;
            shift_p1   <= shift_edge;
            cs_rise_p1 <= cs_rise;
            cs_fall_p1 <= cs_fall;
        end
    end

    // ---- stage 2: frame FSM, shift registers and TX buffer ----
    state_t            state, state_next;
    logic [DATA_W-1:0] tx_buf, tx_buf_next;
    logic              tx_full, tx_full_next;
    logic [DATA_W-1:0] tx_sh, tx_sh_next;
    logic [DATA_W-1:0] rx_sh, rx_sh_next;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              first_shift, first_shift_next;
    logic [DATA_W-1:0] rx_data_next;
    logic              rx_valid_next, rx_abort_next;
    logic              consume;
    logic [DATA_W-1:0] reload_word;

    assign reload_word = tx_full ? tx_buf : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            first_shift <= 1'b0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            rx_abort_o  <= 1'b0;
        end else begin
            state       <= state_next;
            tx_buf      <= tx_buf_next;
            tx_full     <= tx_full_next;
            tx_sh       <= tx_sh_next;
            rx_sh       <= rx_sh_next;
            bit_cnt     <= bit_cnt_next;
            first_shift <= first_shift_next;
            rx_data_o   <= rx_data_next;
            rx_valid_o  <= rx_valid_next;
            rx_abort_o  <= rx_abort_next;
        end
    end

    always_comb begin
        state_next       = state;
        tx_sh_next       = tx_sh;
        rx_sh_next       = rx_sh;
        bit_cnt_next     = bit_cnt;
        first_shift_next = first_shift;
        rx_data_next     = rx_data_o;
        rx_valid_next    = 1'b0;
        rx_abort_next    = 1'b0;
        consume          = 1'b0;

        unique case (state)
            IDLE: begin
                if (cs_fall_p1) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                tx_sh_next       = reload_word;
                consume          = 1'b1;
                bit_cnt_next     = '0;
                first_shift_next = CPHA;
                state_next       = SHIFT;
                // A select pulse too short to reach SHIFT still ends the frame.
                if (cs_rise_p1) begin
                    tx_sh_next = '0;
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (sample_p1) begin
                    rx_sh_next = {rx_sh[DATA_W-2:0], mosi_p1};
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        rx_data_next  = rx_sh_next;
                        rx_valid_next = 1'b1;
                        bit_cnt_next  = '0;
                        // CPHA=1: the next word must be on MISO before the
                        // following leading edge, which must not shift it.
                        if (CPHA) begin
                            tx_sh_next       = reload_word;
                            consume          = 1'b1;
                            first_shift_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else if (shift_p1) begin
                    if (first_shift) begin
                        first_shift_next = 1'b0;
                    end else if (!CPHA && bit_cnt == '0) begin
                        // CPHA=0: the shift edge after the last sample of a
                        // word presents the next word's MSB.
                        tx_sh_next = reload_word;
                        consume    = 1'b1;
                    end else begin
                        tx_sh_next = {tx_sh[DATA_W-2:0], 1'b0};
                    end
                end

                // Evaluated after the sample so a word completing in the
                // same cycle counts as valid rather than aborted.
                if (cs_rise_p1) begin
                    rx_abort_next = (bit_cnt_next != '0);
                    bit_cnt_next  = '0;
                    tx_sh_next    = '0;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A buffer consumed this cycle still reads as full, so a simultaneous
    // load is refused and the client retries.
    always_comb begin
        tx_buf_next  = tx_buf;
        tx_full_next = tx_full;
        if (consume) begin
            tx_full_next = 1'b0;
        end
        if (tx_load_i && !tx_full) begin
            tx_buf_next  = tx_data_i;
            tx_full_next = 1'b1;
        end
    end

    assign tx_ready_o = ~tx_full;
    assign busy_o     = (state != IDLE);
    assign miso_oe_o  = ~cs_n_s;
    assign miso_o     = ~cs_n_s & tx_sh[DATA_W-1];

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Directed bench for spi_slave: a mode-3 instance at 100 kHz SCLK and a
// mode-0 instance at clk/8, with a received-word scoreboard per instance.
module tb_spi_slave;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nvec = 0;
    int nerr = 0;

    // Mode 3 instance
    logic       sclk3 = 1'b1, cs3 = 1'b1, mosi3 = 1'b0;
    logic       miso3, miso_oe3, tx_ready3, rx_valid3, rx_abort3, busy3;
    logic [7:0] tx_data3 = 8'h00, rx_data3;
    logic       tx_load3 = 1'b0;

    // Mode 0 instance
    logic       sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
    logic       miso0, miso_oe0, tx_ready0, rx_valid0, rx_abort0, busy0;
    logic [7:0] tx_data0 = 8'h00, rx_data0;
    logic       tx_load0 = 1'b0;

    spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .DATA_W(8)) dut3 (
        .clk_i(clk), .reset_i(reset), .sclk_i(sclk3), .cs_n_i(cs3), .mosi_i(mosi3),
        .miso_o(miso3), .miso_oe_o(miso_oe3), .tx_data_i(tx_data3), .tx_load_i(tx_load3),
        .tx_ready_o(tx_ready3), .rx_data_o(rx_data3), .rx_valid_o(rx_valid3),
        .rx_abort_o(rx_abort3), .busy_o(busy3)
    );

    spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .DATA_W(8)) dut0 (
        .clk_i(clk), .reset_i(reset), .sclk_i(sclk0), .cs_n_i(cs0), .mosi_i(mosi0),
        .miso_o(miso0), .miso_oe_o(miso_oe0), .tx_data_i(tx_data0), .tx_load_i(tx_load0),
        .tx_ready_o(tx_ready0), .rx_data_o(rx_data0), .rx_valid_o(rx_valid0),
        .rx_abort_o(rx_abort0), .busy_o(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: expected received words, popped on each rx_valid pulse.
    logic [7:0] q3[$];
    logic [7:0] q0[$];
    int valid_cnt3 = 0, abort_cnt3 = 0, valid_cnt0 = 0, abort_cnt0 = 0;
    int last_valid_cyc3 = 0, last_trail_cyc3 = 0;

    always @(negedge clk) begin
        if (rx_valid3 === 1'b1) begin
            valid_cnt3++;
            last_valid_cyc3 = cyc;
            if (q3.size() == 0) check("rx3_unexpected_valid", 32'd1, 32'd0);
            else check("rx3_data", {24'd0, rx_data3}, {24'd0, q3.pop_front()});
        end
        if (rx_abort3 === 1'b1) abort_cnt3++;
        if (rx_valid0 === 1'b1) begin
            valid_cnt0++;
            if (q0.size() == 0) check("rx0_unexpected_valid", 32'd1, 32'd0);
            else check("rx0_data", {24'd0, rx_data0}, {24'd0, q0.pop_front()});
        end
        if (rx_abort0 === 1'b1) abort_cnt0++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load3(input logic [7:0] v);
        tx_data3 = v;
        tx_load3 = 1'b1;
        tick(1);
        tx_load3 = 1'b0;
    endtask

    // Mode 3 master: data changes on the falling (leading) edge, both ends
    // sample on the rising (trailing) edge; SCLK half period 50 clocks.
    task automatic xfer3(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sclk3 = 1'b0;
            mosi3 = mo[i];
            tick(50);
            mi[i] = miso3;
            sclk3 = 1'b1;
            last_trail_cyc3 = cyc;
            tick(50);
        end
    endtask

    // Mode 0 master: data set while SCLK low, sampled on the rising edge;
    // SCLK half period 4 clocks.
    task automatic xfer0(input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            sclk0 = 1'b0;
            mosi0 = mo[i];
            tick(4);
            mi[i] = miso0;
            sclk0 = 1'b1;
            tick(4);
        end
        sclk0 = 1'b0;
        tick(4);
    endtask

    logic [7:0] mi;

    initial begin
        // Reset state
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_miso", miso3, 1'b0);
        check("rst_miso_oe", miso_oe3, 1'b0);
        check("rst_tx_ready", tx_ready3, 1'b1);
        check("rst_rx_data", rx_data3, 8'h00);
        check("rst_rx_valid", rx_valid3, 1'b0);
        check("rst_rx_abort", rx_abort3, 1'b0);
        check("rst_busy", busy3, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_tx_ready0", tx_ready0, 1'b1);

        // Mode 3: preload 0x3C, receive 0xA5
        load3(8'h3C);
        check("t1_ready_after_load", tx_ready3, 1'b0);
        load3(8'hEE);  // ignored: buffer full
        cs3 = 1'b0;
        q3.push_back(8'hA5);
        tick(20);
        check("t1_busy", busy3, 1'b1);
        check("t1_miso_oe", miso_oe3, 1'b1);
        check("t1_ready_after_load_state", tx_ready3, 1'b1);
        xfer3(8'hA5, 8, mi);
        check("t1_miso_word", mi, 8'h3C);
        check("t1_valid_latency", last_valid_cyc3 - last_trail_cyc3, 32'd4);
        check("t1_valid_count", valid_cnt3, 32'd1);
        cs3 = 1'b1;
        tick(10);
        check("t1_busy_end", busy3, 1'b0);
        check("t1_rx_data", rx_data3, 8'hA5);
        check("t1_miso_oe_end", miso_oe3, 1'b0);

        // Mode 3: no preload, receive 0xFF
        cs3 = 1'b0;
        q3.push_back(8'hFF);
        tick(20);
        xfer3(8'hFF, 8, mi);
        check("t2_miso_word", mi, 8'h00);
        cs3 = 1'b1;
        tick(10);
        check("t2_valid_count", valid_cnt3, 32'd2);
        check("t2_rx_data", rx_data3, 8'hFF);

        // Mode 3: two words in one frame with a reload between them
        load3(8'h12);
        cs3 = 1'b0;
        q3.push_back(8'h55);
        q3.push_back(8'hAA);
        tick(20);
        check("t3_ready_before_reload", tx_ready3, 1'b1);
        load3(8'h34);
        check("t3_ready_after_reload", tx_ready3, 1'b0);
        xfer3(8'h55, 8, mi);
        check("t3_miso_word0", mi, 8'h12);
        xfer3(8'hAA, 8, mi);
        check("t3_miso_word1", mi, 8'h34);
        cs3 = 1'b1;
        tick(10);
        check("t3_valid_count", valid_cnt3, 32'd4);
        check("t3_rx_data", rx_data3, 8'hAA);
        check("t3_queue_empty", q3.size(), 32'd0);
        check("t3_no_abort", abort_cnt3, 32'd0);

        // Mode 3: CS_n released after 4 bits
        cs3 = 1'b0;
        tick(20);
        xfer3(8'h0F, 4, mi);
        cs3 = 1'b1;
        tick(4);
        check("t4_busy_released", busy3, 1'b0);
        tick(6);
        check("t4_abort_count", abort_cnt3, 32'd1);
        check("t4_valid_count", valid_cnt3, 32'd4);
        check("t4_rx_data_kept", rx_data3, 8'hAA);

        // Mode 3: reset mid-word, then a clean 0xC3 frame
        cs3 = 1'b0;
        tick(20);
        xfer3(8'hFF, 3, mi);
        reset = 1'b1;
        tick(1);
        check("t5_rst_busy", busy3, 1'b0);
        check("t5_rst_miso_oe", miso_oe3, 1'b0);
        check("t5_rst_miso", miso3, 1'b0);
        check("t5_rst_tx_ready", tx_ready3, 1'b1);
        check("t5_rst_rx_data", rx_data3, 8'h00);
        check("t5_rst_rx_valid", rx_valid3, 1'b0);
        check("t5_rst_rx_abort", rx_abort3, 1'b0);
        reset = 1'b0;
        cs3 = 1'b1;
        sclk3 = 1'b1;
        tick(20);
        cs3 = 1'b0;
        q3.push_back(8'hC3);
        tick(20);
        xfer3(8'hC3, 8, mi);
        cs3 = 1'b1;
        tick(10);
        check("t5_valid_count", valid_cnt3, 32'd5);
        check("t5_rx_data", rx_data3, 8'hC3);
        check("t5_abort_count", abort_cnt3, 32'd1);
        check("t5_queue_empty", q3.size(), 32'd0);

        // Mode 0 at clk/8: preload 0x81, receive 0x7E
        tx_data0 = 8'h81;
        tx_load0 = 1'b1;
        tick(1);
        tx_load0 = 1'b0;
        check("t6_ready_after_load", tx_ready0, 1'b0);
        cs0 = 1'b0;
        mosi0 = 1'b0;
        q0.push_back(8'h7E);
        tick(20);
        check("t6_busy", busy0, 1'b1);
        xfer0(8'h7E, mi);
        check("t6_miso_word", mi, 8'h81);
        cs0 = 1'b1;
        tick(10);
        check("t6_valid_count", valid_cnt0, 32'd1);
        check("t6_rx_data", rx_data0, 8'h7E);
        check("t6_no_abort", abort_cnt0, 32'd0);
        check("t6_busy_end", busy0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
